clock_ratio_switcher: RTL and testbench

//  Single-clock programmable divider producing a divided clock (clk_out) and an aligned
//  one-cycle enable strobe (tick) at ratios /2../32. Sits downstream of the fixed

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/ratio_counter.sv | 49 ++++
 rtl/clock_ratio_switcher.sv | 101 ++++++++++
 tb/tb_clock_ratio_switcher.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants, switcher FSM state type and ratio helper for the clock divider family.
package clkdiv_pkg;

    localparam int SEL_MIN = 1;
    localparam int SEL_MAX = 5;
    localparam int CNT_W   = 5;

    typedef enum logic {
        RUN,
        PEND
    } sw_state_t;

    // Terminal count for ratio 2**sel, i.e. the last cnt value of a period.
    function automatic logic [CNT_W-1:0] ratio_m1(input int sel);
        return CNT_W'((32'd1 << sel) - 32'd1);
    endfunction

endpackage

// File: rtl/ratio_counter.sv
// Period counter for the ratio switcher: wrap detection plus registered clk_out and tick
// derived from the next-state count so they stay aligned with cnt.
module ratio_counter
    import clkdiv_pkg::*;
#(
    parameter int DEFAULT_SEL = 1,
    parameter int SEL_W       = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_cur_sel,
    output logic             o_wrap,
    output logic             o_clk_out,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_ratioM1;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_wrap;
    logic             r_clkOut;
    logic             r_tick;

    assign w_ratioM1 = ratio_m1(int'(i_cur_sel));
    assign w_wrap    = i_en && (r_cnt == w_ratioM1);
    assign w_cntNext = w_wrap ? '0 : r_cnt + CNT_W'(1);

    // A ratio change only lands on a wrap, where the next count is 0, so the old
    // ratio's half-point is still correct for the clk_out decision on that edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= ratio_m1(DEFAULT_SEL);
            r_clkOut <= 1'b0;
            r_tick   <= 1'b0;
        end else if (i_en) begin
            r_cnt    <= w_cntNext;
            r_clkOut <= (w_cntNext <= (w_ratioM1 >> 1));
            r_tick   <= (w_cntNext == '0);
        end else begin
            r_tick   <= 1'b0;
        end
    end

    assign o_wrap    = w_wrap;
    assign o_clk_out = r_clkOut;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clock_ratio_switcher.sv
// Programmable /2../32 divider with a valid/ready ratio request that is only applied on a
// period boundary, so clk_out never shows a runt or stretched pulse.
module clock_ratio_switcher
    import clkdiv_pkg::*;
#(
    parameter int DEFAULT_SEL = 1,
    parameter int SEL_W       = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_sel_valid,
    output logic             o_sel_ready,
    output logic [SEL_W-1:0] o_cur_sel,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_sel_err
);

    sw_state_t        r_state;
    sw_state_t        w_stateNext;
    logic [SEL_W-1:0] r_curSel;
    logic [SEL_W-1:0] w_curSelNext;
    logic [SEL_W-1:0] r_pendSel;
    logic [SEL_W-1:0] w_pendSelNext;
    logic             r_selErr;
    logic             w_selErrNext;
    logic             w_wrap;
    logic             w_accept;
    logic             w_legal;

    assign w_accept = i_sel_valid && (r_state == RUN);
    assign w_legal  = (int'(i_sel) >= SEL_MIN) && (int'(i_sel) <= SEL_MAX);

    ratio_counter #(
        .DEFAULT_SEL (DEFAULT_SEL),
        .SEL_W       (SEL_W)
    ) u_counter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_cur_sel (r_curSel),
        .o_wrap    (w_wrap),
        .o_clk_out (o_clk_out),
        .o_tick    (o_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RUN;
            r_curSel  <= SEL_W'(DEFAULT_SEL);
            r_pendSel <= '0;
            r_selErr  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_curSel  <= w_curSelNext;
            r_pendSel <= w_pendSelNext;
            r_selErr  <= w_selErrNext;
        end
    end

    // A request that arrives exactly on the wrap edge is applied at once; any other
    // legal request (including one equal to the current ratio) waits in PEND.
    always_comb begin
        w_stateNext   = r_state;
        w_curSelNext  = r_curSel;
        w_pendSelNext = r_pendSel;
        w_selErrNext  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_selErrNext = 1'b1;
                    end else begin
                        w_pendSelNext = i_sel;
                        if (w_wrap) begin
                            w_curSelNext = i_sel;
                        end else begin
                            w_stateNext = PEND;
                        end
                    end
                end
            end
            PEND: begin
                if (w_wrap) begin
                    w_curSelNext = r_pendSel;
                    w_stateNext  = RUN;
                end
            end
            default: w_stateNext = RUN;
        endcase
    end

    assign o_sel_ready = (r_state == RUN);
    assign o_busy      = (r_state == PEND);
    assign o_cur_sel   = r_curSel;
    assign o_sel_err   = r_selErr;

endmodule

// File: tb/tb_clock_ratio_switcher.sv
// Scoreboard bench for clock_ratio_switcher: a behavioural period model pushes the expected
// outputs for every driven edge, and each scenario task pops and compares them after the edge.
module tb_clock_ratio_switcher;

    typedef struct packed {
        logic       clkOut;
        logic       tick;
        logic       busy;
        logic       selErr;
        logic       selReady;
        logic [2:0] curSel;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b0;
    logic       en       = 1'b0;
    logic       selValid = 1'b0;
    logic [2:0] sel      = 3'd0;

    logic       o_sel_ready;
    logic [2:0] o_cur_sel;
    logic       o_clk_out;
    logic       o_tick;
    logic       o_busy;
    logic       o_sel_err;

    exp_t actual;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model state: position inside the period, active exponent, pending request.
    int mSel;
    int mPos;
    int mPendSel;
    bit mPending;
    bit mClk;

    clock_ratio_switcher #(
        .DEFAULT_SEL (1),
        .SEL_W       (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_en        (en),
        .i_sel       (sel),
        .i_sel_valid (selValid),
        .o_sel_ready (o_sel_ready),
        .o_cur_sel   (o_cur_sel),
        .o_clk_out   (o_clk_out),
        .o_tick      (o_tick),
        .o_busy      (o_busy),
        .o_sel_err   (o_sel_err)
    );

    assign actual = {o_clk_out, o_tick, o_busy, o_sel_err, o_sel_ready, o_cur_sel};

    always #5 clk = ~clk;

    task automatic modelReset();
        mSel     = 1;
        mPos     = 1;
        mPendSel = 0;
        mPending = 1'b0;
        mClk     = 1'b0;
        sb.delete();
    endtask

    // Advance the model by one edge with the inputs currently driven, queue the expected
    // outputs, then step the DUT one clock and return 1 time unit after the edge.
    task automatic applyStimulus();
        exp_t e;
        int   r;
        bit   accept;
        bit   legal;
        bit   last;
        r      = 1 << mSel;
        accept = selValid && !mPending;
        legal  = (int'(sel) >= 1) && (int'(sel) <= 5);
        last   = en && (mPos == r - 1);
        e.selErr = accept && !legal;
        if (last) begin
            if (accept && legal) begin
                mSel = int'(sel);
            end else if (mPending) begin
                mSel     = mPendSel;
                mPending = 1'b0;
            end
            mPos = 0;
        end else if (en) begin
            mPos = mPos + 1;
        end
        if (accept && legal && !last) begin
            mPending = 1'b1;
            mPendSel = int'(sel);
        end
        r = 1 << mSel;
        if (en) mClk = (mPos < r / 2);
        e.clkOut   = mClk;
        e.tick     = en && (mPos == 0);
        e.busy     = mPending;
        e.selReady = !mPending;
        e.curSel   = 3'(mSel);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstN = 1'b0; en = 1'b1; selValid = 1'b0; sel = 3'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        checks++;
        if (actual !== e) begin
            errors++;
            $display("[TB] FAIL reset_values got=%b exp=%b", actual, e);
        end
        rstN = 1'b1;
    endtask

    task automatic test_default_ratio();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL default_sb cyc=%0d got=%b exp=%b", i, actual, e);
            end
            checks++;
            if (o_clk_out !== (i % 2 == 0) || o_tick !== (i % 2 == 0)) begin
                errors++;
                $display("[TB] FAIL default_pattern cyc=%0d clk_out=%b tick=%b exp=%b", i, o_clk_out, o_tick, (i % 2 == 0));
            end
        end
    endtask

    task automatic test_change_up();
        exp_t e;
        int   busyCycles = 0;
        int   highs      = 0;
        int   ticks      = 0;
        for (int k = 0; k < 4 && mPos != 0; k++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL up_sync got=%b exp=%b", actual, e);
            end
        end
        sel = 3'd3;
        for (int i = 0; i < 17; i++) begin
            selValid = (i == 0);
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL up_sb cyc=%0d got=%b exp=%b", i, actual, e);
            end
            if (o_busy) busyCycles++;
            if (i >= 1) begin
                if (o_clk_out) highs++;
                if (o_tick) ticks++;
            end
            if (i == 1) begin
                checks++;
                if (o_cur_sel !== 3'd3 || o_tick !== 1'b1 || o_clk_out !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL up_switch cur_sel=%0d tick=%b clk_out=%b exp=3/1/1", o_cur_sel, o_tick, o_clk_out);
                end
            end
        end
        selValid = 1'b0;
        checks++;
        if (busyCycles != 1 || highs != 8 || ticks != 2) begin
            errors++;
            $display("[TB] FAIL up_shape busy=%0d highs=%0d ticks=%0d exp=1/8/2", busyCycles, highs, ticks);
        end
    endtask

    task automatic test_change_down();
        exp_t e;
        int   highs      = 0;
        int   busyCycles = 0;
        bit   synced     = 1'b0;
        sel = 3'd5; selValid = 1'b1;
        applyStimulus();
        selValid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (actual !== e) begin
            errors++;
            $display("[TB] FAIL down_req got=%b exp=%b", actual, e);
        end
        for (int k = 0; k < 80 && !synced; k++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL down_sync got=%b exp=%b", actual, e);
            end
            synced = (mSel == 5) && !mPending && (mPos == 31);
        end
        checks++;
        if (!synced) begin
            errors++;
            $display("[TB] FAIL down_timeout synced=%b exp=1", synced);
        end
        sel = 3'd1;
        for (int k = 1; k <= 40; k++) begin
            selValid = (k == 7);
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL down_sb edge=%0d got=%b exp=%b", k, actual, e);
            end
            if (k <= 32) begin
                if (o_clk_out) highs++;
                if (o_busy) busyCycles++;
            end
            if (k == 32 || k == 33) begin
                checks++;
                if (o_cur_sel !== ((k == 32) ? 3'd5 : 3'd1)) begin
                    errors++;
                    $display("[TB] FAIL down_cur_sel edge=%0d got=%0d exp=%0d", k, o_cur_sel, (k == 32) ? 5 : 1);
                end
            end
        end
        selValid = 1'b0;
        checks++;
        if (highs != 16 || busyCycles != 26) begin
            errors++;
            $display("[TB] FAIL down_period highs=%0d busy=%0d exp=16/26", highs, busyCycles);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        int   errPulses = 0;
        for (int i = 0; i < 6; i++) begin
            sel      = (i == 0) ? 3'd0 : 3'd7;
            selValid = (i == 0 || i == 2);
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL illegal_sb cyc=%0d got=%b exp=%b", i, actual, e);
            end
            if (o_sel_err) errPulses++;
            checks++;
            if (o_sel_ready !== 1'b1 || o_cur_sel !== 3'd1) begin
                errors++;
                $display("[TB] FAIL illegal_hold ready=%b cur_sel=%0d exp=1/1", o_sel_ready, o_cur_sel);
            end
        end
        selValid = 1'b0;
        checks++;
        if (errPulses != 2) begin
            errors++;
            $display("[TB] FAIL illegal_pulses got=%0d exp=2", errPulses);
        end
    endtask

    task automatic test_en_freeze();
        exp_t e;
        for (int k = 0; k < 4 && mPos != 0; k++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL freeze_sync got=%b exp=%b", actual, e);
            end
        end
        sel = 3'd2; selValid = 1'b1;
        applyStimulus();
        selValid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (actual !== e) begin
            errors++;
            $display("[TB] FAIL freeze_req got=%b exp=%b", actual, e);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL freeze_sb cyc=%0d got=%b exp=%b", i, actual, e);
            end
            checks++;
            if (o_clk_out !== 1'b0 || o_tick !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL freeze_hold clk_out=%b tick=%b busy=%b exp=0/0/1", o_clk_out, o_tick, o_busy);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL freeze_resume cyc=%0d got=%b exp=%b", i, actual, e);
            end
            if (i == 0) begin
                checks++;
                if (o_cur_sel !== 3'd2 || o_tick !== 1'b1 || o_busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL freeze_switch cur_sel=%0d tick=%b busy=%b exp=2/1/0", o_cur_sel, o_tick, o_busy);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        exp_t rv;
        rv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        for (int k = 0; k < 8 && mPos != 0; k++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL areset_sync got=%b exp=%b", actual, e);
            end
        end
        sel = 3'd5; selValid = 1'b1;
        applyStimulus();
        selValid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (actual !== e || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pend got=%b exp=%b", actual, e);
        end
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checks++;
        if (actual !== rv) begin
            errors++;
            $display("[TB] FAIL areset_immediate got=%b exp=%b", actual, rv);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (actual !== rv) begin
            errors++;
            $display("[TB] FAIL areset_held got=%b exp=%b", actual, rv);
        end
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            e = sb.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("[TB] FAIL areset_after cyc=%0d got=%b exp=%b", i, actual, e);
            end
            checks++;
            if (o_cur_sel !== 3'd1 || o_clk_out !== (i % 2 == 0)) begin
                errors++;
                $display("[TB] FAIL areset_ratio cur_sel=%0d clk_out=%b exp=1/%b", o_cur_sel, o_clk_out, (i % 2 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_ratio();
        test_change_up();
        test_change_down();
        test_illegal();
        test_en_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog_expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
